calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Calculator sequencer that sits between the keypad decoder and the shared BCD ALU. It assembles BCD operands from single-cycle key events and latches the operator. On "equals" it drives the ALU operand/op inputs, waits a fixed ALU latency, then captures the result for the display. It also owns divide-by-zero detection, clear/abort and result reuse.

Parameters:
DIGITS, 4, BCD digits per operand; data width W = 4*DIGITS (16 at default).
ALU_LAT, 2, clock cycles from ALU inputs stable to alu_res valid; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
key_valid  in  1  one-cycle strobe qualifying key_code.
key_code  in  4  0x0-0x9 digit; 0xA equals; 0xB clear; 0xC add, 0xD sub, 0xE mul, 0xF div (identical to ALU op codes).
alu_res  in  W  ALU result, BCD.
alu_num1  out  W  ALU operand A, registered.
alu_num2  out  W  ALU operand B, registered.
alu_op  out  4  ALU op code, registered.
display  out  W  BCD value to show, registered.
busy  out  1  high while in S_EXEC.
done  out  1  one-cycle pulse: result captured.
err  out  1  high while in S_ERR.

Behaviour:
- Reset (async, any state, including mid-S_EXEC): state=S_A, acc_a=acc_b=0, digit counters=0, latched op=0xC. alu_num1/alu_num2=0, alu_op=0xC, display=0, busy=done=err=0.
- Keys are sampled only when key_valid=1. Back-to-back strobes on consecutive cycles are each processed.
- Digit entry: acc = {acc[W-5:0], digit}, count+1. Once count==DIGITS, further digits are ignored and acc is unchanged. Display shows the operand currently being entered.
- S_A: digit -> shift into acc_a. Op key -> latch op, clear acc_b/count_b, go S_B; display keeps acc_a. Equals -> ignored.
- S_B: digit -> shift into acc_b. Op key with count_b==0 -> replace latched op, stay in S_B. Op key with count_b>0 -> see Optional Feature. Equals with count_b==0 -> ignored. Equals with op==0xF and acc_b==0 -> go S_ERR; ALU outputs unchanged. Otherwise equals -> load alu_num1=acc_a, alu_num2=acc_b, alu_op=op on the same edge, set cnt=ALU_LAT, go S_EXEC.
- S_EXEC: busy=1; ALU outputs held stable; cnt decrements each cycle. On the edge where cnt==0: result=alu_res, display=alu_res, done=1 for the following cycle, go S_RES. Net timing: capture on the (ALU_LAT+1)th rising edge after the edge that sampled equals. Digit/op/equals keys are dropped in this state.
- S_RES: digit -> acc_a={0..,digit}, count_a=1, go S_A. Op key -> acc_a=result, latch op, clear acc_b, go S_B. Equals -> ignored.
- S_ERR: err=1, display=0. Only clear exits (to S_A); all other keys are ignored.
- Clear (0xB) in any state: synchronous return to reset values, including abort of S_EXEC. done is not pulsed. ALU outputs return to 0/0xC.
- Same-edge priority: rst > clear > cnt expiry > other keys.
- No arithmetic in this block beyond the counter and digit shift; BCD validity of alu_res is not checked.

Optional Feature:
CALC_CHAIN_EN. Defined: an op key in S_B with count_b>0 behaves as equals (including the div-by-zero check). The new op is stored as pending. On capture the FSM goes to S_B instead of S_RES, with acc_a=result, op=pending and acc_b cleared; done still pulses. Undefined: that op key is ignored and the latched op is unchanged.

Test Plan:
1. Keys 1,4,F,7,A (ALU_LAT=2) -> alu_num1=0x0014, alu_num2=0x0007, alu_op=0xF on equals edge; busy 3 cycles; display=alu_res and done pulse exactly 3 edges after equals edge.
2. Keys 1,2,3,4,5 -> display=0x1234; 5th digit ignored; then C,9,9,9,9,9,A -> alu_num2=0x9999.
3. Keys 8,F,0,A -> err=1, display=0, ALU outputs unchanged; then 5 -> still err; then B -> err=0, state S_A, display=0.
4. Keys 5,0,0,0,C,4,0,0,0,A, then B one cycle after equals -> busy drops, no done pulse, all outputs at reset values; same case with rst asserted mid-S_EXEC -> identical outcome, asynchronously.
5. After result 0x9000 in S_RES: key D,1,A -> alu_num1=0x9000, alu_num2=0x0001, alu_op=0xD. Separately, key 7 in S_RES -> display=0x0007.
6. With CALC_CHAIN_EN: 2,C,3,E,4,A -> first exec num1=0x0002/num2=0x0003/op=0xC; second exec num1=alu_res/num2=0x0004/op=0xE; two done pulses. Without the macro -> single exec 2 + 34, op=0xC.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: builds BCD operands from key strobes, launches the shared ALU and captures its result.
// Optional macro CALC_CHAIN_EN: an operator key after a non-empty second operand evaluates and chains the result.
module calc_seq_ctrl #(
    parameter int DIGITS  = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic [4*DIGITS-1:0] alu_res,
    output logic [4*DIGITS-1:0] alu_num1,
    output logic [4*DIGITS-1:0] alu_num2,
    output logic [3:0]          alu_op,
    output logic [4*DIGITS-1:0] display,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [3:0] KEY_EQ  = 4'hA;
    localparam logic [3:0] KEY_CLR = 4'hB;
    localparam logic [3:0] OP_ADD  = 4'hC;
    localparam logic [3:0] OP_DIV  = 4'hF;

    typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_RES, S_ERR} state_t;

    state_t        state, state_d;
    logic [W-1:0]  acc_a, acc_a_d, acc_b, acc_b_d, result, result_d;
    logic [W-1:0]  num1_d, num2_d, display_d;
    logic [CW-1:0] cnt_a, cnt_a_d, cnt_b, cnt_b_d;
    logic [3:0]    op, op_d, op_alu_d, cnt, cnt_d;
    logic          done_d, launch;
    logic          is_digit, is_op, is_eq, is_clr;
`ifdef CALC_CHAIN_EN
    logic [3:0]    pend, pend_d;
    logic          chain, chain_d, chain_req;
`endif

    assign is_digit = key_valid && (key_code <= 4'h9);
    assign is_op    = key_valid && (key_code >= OP_ADD);
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);

    assign busy = (state == S_EXEC);
    assign err  = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_A;
            acc_a    <= '0;
            acc_b    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            op       <= OP_ADD;
            cnt      <= '0;
            result   <= '0;
            alu_num1 <= '0;
            alu_num2 <= '0;
            alu_op   <= OP_ADD;
            display  <= '0;
            done     <= 1'b0;
`ifdef CALC_CHAIN_EN
            pend     <= OP_ADD;
            chain    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            acc_a    <= acc_a_d;
            acc_b    <= acc_b_d;
            cnt_a    <= cnt_a_d;
            cnt_b    <= cnt_b_d;
            op       <= op_d;
            cnt      <= cnt_d;
            result   <= result_d;
            alu_num1 <= num1_d;
            alu_num2 <= num2_d;
            alu_op   <= op_alu_d;
            display  <= display_d;
            done     <= done_d;
`ifdef CALC_CHAIN_EN
            pend     <= pend_d;
            chain    <= chain_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        acc_a_d   = acc_a;
        acc_b_d   = acc_b;
        cnt_a_d   = cnt_a;
        cnt_b_d   = cnt_b;
        op_d      = op;
        cnt_d     = cnt;
        result_d  = result;
        num1_d    = alu_num1;
        num2_d    = alu_num2;
        op_alu_d  = alu_op;
        display_d = display;
        done_d    = 1'b0;
        launch    = 1'b0;
`ifdef CALC_CHAIN_EN
        pend_d    = pend;
        chain_d   = chain;
        chain_req = 1'b0;
`endif
        // Clear outranks counter expiry, so an aborted execution never pulses done.
        if (is_clr) begin
            state_d   = S_A;
            acc_a_d   = '0;
            acc_b_d   = '0;
            cnt_a_d   = '0;
            cnt_b_d   = '0;
            op_d      = OP_ADD;
            cnt_d     = '0;
            result_d  = '0;
            num1_d    = '0;
            num2_d    = '0;
            op_alu_d  = OP_ADD;
            display_d = '0;
`ifdef CALC_CHAIN_EN
            pend_d    = OP_ADD;
            chain_d   = 1'b0;
`endif
        end else begin
            unique case (state)
                S_A: begin
                    if (is_digit) begin
                        if (cnt_a != CNT_FULL) begin
                            acc_a_d   = W'({acc_a, key_code});
                            cnt_a_d   = cnt_a + CW'(1);
                            display_d = acc_a_d;
                        end
                    end else if (is_op) begin
                        op_d    = key_code;
                        acc_b_d = '0;
                        cnt_b_d = '0;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        if (cnt_b != CNT_FULL) begin
                            acc_b_d   = W'({acc_b, key_code});
                            cnt_b_d   = cnt_b + CW'(1);
                            display_d = acc_b_d;
                        end
                    end else if (is_op) begin
                        if (cnt_b == '0) begin
                            op_d = key_code;
                        end else begin
`ifdef CALC_CHAIN_EN
                            launch    = 1'b1;
                            chain_req = 1'b1;
                            pend_d    = key_code;
`endif
                        end
                    end else if (is_eq && (cnt_b != '0)) begin
                        launch = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        result_d  = alu_res;
                        display_d = alu_res;
                        done_d    = 1'b1;
                        state_d   = S_RES;
`ifdef CALC_CHAIN_EN
                        if (chain) begin
                            acc_a_d = alu_res;
                            op_d    = pend;
                            acc_b_d = '0;
                            cnt_b_d = '0;
                            chain_d = 1'b0;
                            state_d = S_B;
                        end
`endif
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        acc_a_d   = W'(key_code);
                        cnt_a_d   = CW'(1);
                        display_d = acc_a_d;
                        state_d   = S_A;
                    end else if (is_op) begin
                        acc_a_d = result;
                        op_d    = key_code;
                        acc_b_d = '0;
                        cnt_b_d = '0;
                        state_d = S_B;
                    end
                end
                S_ERR: ;
                default: state_d = S_A;
            endcase

            // Division by zero is caught before the ALU inputs are touched.
            if (launch) begin
                if ((op == OP_DIV) && (acc_b == '0)) begin
                    state_d   = S_ERR;
                    display_d = '0;
                end else begin
                    num1_d   = acc_a;
                    num2_d   = acc_b;
                    op_alu_d = op;
                    cnt_d    = 4'(ALU_LAT);
                    state_d  = S_EXEC;
`ifdef CALC_CHAIN_EN
                    chain_d  = chain_req;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: a key-level behavioural model checked every cycle,
// plus directed key sequences with literal expectations.
module tb_calc_seq_ctrl;
    localparam int DIGITS  = 4;
    localparam int ALU_LAT = 2;
    localparam int W       = 4 * DIGITS;

    logic         clk, rst, key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] alu_res, alu_num1, alu_num2, display;
    logic [3:0]   alu_op;
    logic         busy, done, err;

    int total = 0;
    int bad   = 0;

    calc_seq_ctrl #(.DIGITS(DIGITS), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_res(alu_res), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_op(alu_op), .display(display), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model phases: 0 entering A, 1 entering B, 2 executing, 3 showing result, 4 error
    int           m_ph, m_na, m_nb;
    logic [W-1:0] m_a, m_b, m_res, m_n1, m_n2, m_disp;
    logic [3:0]   m_op, m_aop, m_pend;
    bit           m_chain, m_done;
    longint       edge_n, m_cap;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_na = 0; m_nb = 0;
        m_a = '0; m_b = '0; m_res = '0; m_n1 = '0; m_n2 = '0; m_disp = '0;
        m_op = 4'hC; m_aop = 4'hC; m_pend = 4'hC;
        m_chain = 0; m_done = 0; m_cap = 0;
    endtask

    task automatic m_launch(bit chain_it, logic [3:0] nxt);
        if (m_op == 4'hF && m_b == 0) begin
            m_ph = 4;
            m_disp = '0;
        end else begin
            m_n1 = m_a; m_n2 = m_b; m_aop = m_op;
            m_chain = chain_it; m_pend = nxt;
            m_cap = edge_n + ALU_LAT + 1;
            m_ph = 2;
        end
    endtask

    task automatic m_key(logic [3:0] k);
        bit dig = (k <= 4'h9);
        bit opk = (k >= 4'hC);
        bit eq  = (k == 4'hA);
        case (m_ph)
            0: begin
                if (dig && m_na < DIGITS) begin
                    m_a = W'(m_a * 16 + k); m_na++; m_disp = m_a;
                end else if (opk) begin
                    m_op = k; m_b = '0; m_nb = 0; m_ph = 1;
                end
            end
            1: begin
                if (dig && m_nb < DIGITS) begin
                    m_b = W'(m_b * 16 + k); m_nb++; m_disp = m_b;
                end else if (opk && m_nb == 0) begin
                    m_op = k;
                end else if (opk) begin
`ifdef CALC_CHAIN_EN
                    m_launch(1, k);
`endif
                end else if (eq && m_nb > 0) begin
                    m_launch(0, 4'hC);
                end
            end
            3: begin
                if (dig) begin
                    m_a = W'(k); m_na = 1; m_disp = m_a; m_ph = 0;
                end else if (opk) begin
                    m_a = m_res; m_op = k; m_b = '0; m_nb = 0; m_ph = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        m_reset();
        edge_n = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                edge_n++;
                m_done = 0;
                if (key_valid && key_code == 4'hB) begin
                    m_reset();
                end else if (m_ph == 2) begin
                    if (edge_n == m_cap) begin
                        m_res = alu_res; m_disp = alu_res; m_done = 1;
                        if (m_chain) begin
                            m_a = alu_res; m_op = m_pend; m_b = '0; m_nb = 0;
                            m_chain = 0; m_ph = 1;
                        end else begin
                            m_ph = 3;
                        end
                    end
                end else if (key_valid) begin
                    m_key(key_code);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_num1", 32'(alu_num1), 32'(m_n1));
            chk("m_num2", 32'(alu_num2), 32'(m_n2));
            chk("m_op", 32'(alu_op), 32'(m_aop));
            chk("m_display", 32'(display), 32'(m_disp));
            chk("m_busy", 32'(busy), 32'(m_ph == 2));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_err", 32'(err), 32'(m_ph == 4));
        end
    end

    task automatic press(logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_num1"}, 32'(alu_num1), 32'h0);
        chk({tag, "_num2"}, 32'(alu_num2), 32'h0);
        chk({tag, "_op"}, 32'(alu_op), 32'hC);
        chk({tag, "_disp"}, 32'(display), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; alu_res = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_outs("reset");

        // 14 / 7 with a two-cycle ALU
        alu_res = 16'h0002;
        press(4'h1); press(4'h4); press(4'hF);
        chk("t1_disp_a", 32'(display), 32'h0014);
        press(4'h7);
        chk("t1_disp_b", 32'(display), 32'h0007);
        press(4'hA);
        chk("t1_num1", 32'(alu_num1), 32'h0014);
        chk("t1_num2", 32'(alu_num2), 32'h0007);
        chk("t1_op", 32'(alu_op), 32'hF);
        chk("t1_busy0", 32'(busy), 32'h1);
        idle(2);
        chk("t1_busy2", 32'(busy), 32'h1);
        chk("t1_nodone", 32'(done), 32'h0);
        idle(1);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_disp", 32'(display), 32'h0002);
        chk("t1_busy3", 32'(busy), 32'h0);
        idle(1);
        chk("t1_done_end", 32'(done), 32'h0);

        // operand width limit
        press(4'hB);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("t2_disp", 32'(display), 32'h1234);
        press(4'hC);
        for (int i = 0; i < 5; i++) press(4'h9);
        chk("t2_disp_b", 32'(display), 32'h9999);
        press(4'hA);
        chk("t2_num1", 32'(alu_num1), 32'h1234);
        chk("t2_num2", 32'(alu_num2), 32'h9999);
        idle(4);

        // divide by zero
        press(4'hB);
        press(4'h8); press(4'hF); press(4'h0); press(4'hA);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_disp", 32'(display), 32'h0);
        chk("t3_num1", 32'(alu_num1), 32'h0);
        chk("t3_op", 32'(alu_op), 32'hC);
        chk("t3_busy", 32'(busy), 32'h0);
        press(4'h5);
        chk("t3_err_hold", 32'(err), 32'h1);
        press(4'hB);
        chk_reset_outs("t3_clr");

        // clear during execution
        alu_res = 16'h9000;
        press(4'h5); press(4'h0); press(4'h0); press(4'h0); press(4'hC);
        press(4'h4); press(4'h0); press(4'h0); press(4'h0); press(4'hA);
        chk("t4_busy", 32'(busy), 32'h1);
        chk("t4_num2", 32'(alu_num2), 32'h4000);
        press(4'hB);
        chk_reset_outs("t4_clr");
        idle(3);
        chk("t4_clr_nodone", 32'(done), 32'h0);

        // async reset during execution
        press(4'h5); press(4'hC); press(4'h4); press(4'hA);
        chk("t4r_busy", 32'(busy), 32'h1);
        idle(1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs("t4_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        chk("t4_rst_nodone", 32'(done), 32'h0);

        // result reuse
        press(4'h1); press(4'hC); press(4'h1); press(4'hA);
        idle(3);
        chk("t5_res", 32'(display), 32'h9000);
        press(4'hD); press(4'h1); press(4'hA);
        chk("t5_num1", 32'(alu_num1), 32'h9000);
        chk("t5_num2", 32'(alu_num2), 32'h0001);
        chk("t5_op", 32'(alu_op), 32'hD);
        alu_res = 16'h8999;
        idle(3);
        chk("t5_res2", 32'(display), 32'h8999);
        press(4'h7);
        chk("t5_digit", 32'(display), 32'h0007);

        // operator chaining
        press(4'hB);
        alu_res = 16'h0005;
        press(4'h2); press(4'hC); press(4'h3);
`ifdef CALC_CHAIN_EN
        press(4'hE);
        chk("t6_num1", 32'(alu_num1), 32'h0002);
        chk("t6_num2", 32'(alu_num2), 32'h0003);
        chk("t6_op", 32'(alu_op), 32'hC);
        idle(3);
        chk("t6_done1", 32'(done), 32'h1);
        press(4'h4);
        chk("t6_disp4", 32'(display), 32'h0004);
        press(4'hA);
        chk("t6_num1b", 32'(alu_num1), 32'h0005);
        chk("t6_num2b", 32'(alu_num2), 32'h0004);
        chk("t6_opb", 32'(alu_op), 32'hE);
        alu_res = 16'h0020;
        idle(3);
        chk("t6_done2", 32'(done), 32'h1);
`else
        press(4'hE);
        chk("t6_nobusy", 32'(busy), 32'h0);
        press(4'h4); press(4'hA);
        chk("t6_num1", 32'(alu_num1), 32'h0002);
        chk("t6_num2", 32'(alu_num2), 32'h0034);
        chk("t6_op", 32'(alu_op), 32'hC);
        idle(3);
        chk("t6_done", 32'(done), 32'h1);
`endif

        // ignored equals and operator replacement
        press(4'hB);
        press(4'h3); press(4'hA);
        chk("t7_eq_a", 32'(busy), 32'h0);
        press(4'hC); press(4'hD); press(4'hA);
        chk("t7_eq_b", 32'(busy), 32'h0);
        press(4'h2); press(4'hA);
        chk("t7_num1", 32'(alu_num1), 32'h0003);
        chk("t7_num2", 32'(alu_num2), 32'h0002);
        chk("t7_op", 32'(alu_op), 32'hD);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
